count_up_timer: RTL and testbench
=================================

// Module: count_up_timer
// PURPOSE
//  Two-digit BCD count-up (elapsed-time) timer; up-counting counterpart to the game's countdown timer.
//  Counts seconds from 00 to a switch-programmed limit, using the shared one-second tick.
//  Reports completion via limit_hit level and hit_pulse strobe.
//  Drives the same tens/ones digit outputs consumed by the 7-segment display path.
// PARAMETERS
//  WRAP      0  0: stop in DONE at limit; 1: reload 00, pulse hit_pulse, keep running
//  DEF_TENS  9  tens digit of limit after reset (BCD, 0-9)
//  DEF_ONES  9  ones digit of limit after reset (BCD, 0-9)
// PORTS
//  clk          in   1  system clock; all state on rising edge
//  rst          in   1  asynchronous, active-low reset
//  one_sec      in   1  one-cycle tick, once per second
//  start        in   1  run request (IDLE->RUN, PAUSE->RUN)
//  pause        in   1  hold request (RUN->PAUSE)
//  clear_digit  in   1  synchronous clear: count=00, state IDLE
//  reconfig     in   1  load limit from switches; count=00, state IDLE
//  switch_num3  in   4  limit tens digit (BCD)
//  switch_num4  in   4  limit ones digit (BCD)
//  num_out_1st  out  4  tens digit of count (BCD)
//  num_out_2nd  out  4  ones digit of count (BCD)
//  running      out  1  1 while state==RUN
//  limit_hit    out  1  1 while state==DONE
//  hit_pulse    out  1  one-cycle strobe when count reaches limit
// BEHAVIOUR
//  Reset (rst=0, async): count=00, limit={DEF_TENS,DEF_ONES}, state IDLE, all outputs 0.
//  All outputs registered. Event sampled at edge n is visible after edge n.
//  FSM states: IDLE, RUN, PAUSE, DONE.
//   IDLE : start -> RUN. If limit==00, start -> DONE instead, with hit_pulse.
//   RUN  : pause -> PAUSE. one_sec -> increment count.
//   PAUSE: start -> RUN. one_sec ignored; count held.
//   DONE : count frozen at limit; start/pause/one_sec ignored.
//  Priority in one cycle: clear_digit > reconfig > start > pause > one_sec.
//   start+pause together in RUN -> stay RUN. start wins.
//   one_sec coincident with pause in RUN -> no increment.
//  Increment (RUN, one_sec):
//   ones 0..8 -> +1.
//   ones==9 -> ones=0, tens+1.
//   tens==9 && ones==9 -> 00 (only reachable if limit exceeds 99 after clamp; never occurs).
//  Limit reached (new count == limit):
//   hit_pulse=1 for that cycle.
//   WRAP=0 -> state DONE.
//   WRAP=1 -> count reloads 00 on the next one_sec instead of incrementing; state stays RUN.
//  reconfig (any state):
//   limit <= switches; each digit >9 clamped to 9.
//   count=00, state IDLE, hit_pulse=0.
//  clear_digit (any state): count=00, state IDLE. Limit unchanged.
//  Reset asserted mid-run: immediate return to reset values; no hit_pulse emitted.
//  Switches are sampled only on reconfig; changes at other times have no effect.
// TESTING
//  1. Reset, reconfig with switches 0/5, start, 5 one_sec ticks:
//     digits 01..05; hit_pulse on 5th tick; limit_hit=1; running=0; further ticks keep 05.
//  2. Limit 1/2, start, 12 ticks:
//     ones 9->0 carry at tick 10 gives 10; hit_pulse at 12; DONE.
//  3. Start, 3 ticks, pause, 4 ticks, start, 1 tick:
//     count 03 held in PAUSE; 04 after resume.
//  4. WRAP=1, limit 0/3, 7 ticks:
//     01,02,03 (hit_pulse), 00, 01, 02, 03 (hit_pulse); running stays 1.
//  5. reconfig with switches F/C:
//     limit 99; count 00; IDLE.
//     reconfig+start in same cycle -> IDLE (reconfig wins).
//  6. Limit 00, start:
//     DONE next cycle with single hit_pulse.
//     rst low mid-RUN -> digits 00, outputs 0 asynchronously.

Source files
------------

// File: rtl/count_up_timer_if.sv
// Control, switch and digit signals of the count-up timer.
// The slave side is the timer; the master side is its controller.
interface count_up_timer_if;
  logic       one_sec;
  logic       start;
  logic       pause;
  logic       clear_digit;
  logic       reconfig;
  logic [3:0] switch_num3;
  logic [3:0] switch_num4;
  logic [3:0] num_out_1st;
  logic [3:0] num_out_2nd;
  logic       running;
  logic       limit_hit;
  logic       hit_pulse;

  modport master (
    output one_sec, start, pause,
    output clear_digit, reconfig,
    output switch_num3, switch_num4,
    input  num_out_1st, num_out_2nd,
    input  running, limit_hit, hit_pulse
  );

  modport slave (
    input  one_sec, start, pause,
    input  clear_digit, reconfig,
    input  switch_num3, switch_num4,
    output num_out_1st, num_out_2nd,
    output running, limit_hit, hit_pulse
  );
endinterface

// File: rtl/count_up_timer.sv
// Two-digit BCD elapsed-seconds timer counting 00 up to a
// switch-programmed limit; stops there or wraps (WRAP=1).
module count_up_timer #(
  parameter bit         WRAP     = 1'b0,
  parameter logic [3:0] DEF_TENS = 4'd9,
  parameter logic [3:0] DEF_ONES = 4'd9
) (
  input  logic             clk,
  input  logic             rst,
  count_up_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] r_lim_t;
  logic [3:0] r_lim_o;
  logic       r_running;
  logic       r_limit_hit;
  logic       r_hit_pulse;

  logic [3:0] w_nxt_t;
  logic [3:0] w_nxt_o;
  logic [3:0] w_sw_t;
  logic [3:0] w_sw_o;
  logic       w_at_lim;
  logic       w_nxt_hit;
  logic       w_lim_zero;

  assign w_sw_t = (bus.switch_num3 > 4'd9) ? 4'd9
                                           : bus.switch_num3;
  assign w_sw_o = (bus.switch_num4 > 4'd9) ? 4'd9
                                           : bus.switch_num4;

  assign w_at_lim   = (r_tens == r_lim_t) &&
                      (r_ones == r_lim_o);
  assign w_lim_zero = (r_lim_t == 4'd0) &&
                      (r_lim_o == 4'd0);

  // In wrap mode a tick taken while sitting on the limit reloads 00.
  always_comb begin
    w_nxt_t = r_tens;
    w_nxt_o = r_ones + 4'd1;
    if (WRAP && w_at_lim) begin
      w_nxt_t = 4'd0;
      w_nxt_o = 4'd0;
    end else if (r_ones == 4'd9) begin
      w_nxt_o = 4'd0;
      w_nxt_t = (r_tens == 4'd9) ? 4'd0
                                 : r_tens + 4'd1;
    end
  end

  assign w_nxt_hit = (w_nxt_t == r_lim_t) &&
                     (w_nxt_o == r_lim_o);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_lim_t     <= DEF_TENS;
      r_lim_o     <= DEF_ONES;
      r_running   <= 1'b0;
      r_limit_hit <= 1'b0;
      r_hit_pulse <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      if (bus.clear_digit) begin
        r_state     <= S_IDLE;
        r_tens      <= 4'd0;
        r_ones      <= 4'd0;
        r_running   <= 1'b0;
        r_limit_hit <= 1'b0;
      end else if (bus.reconfig) begin
        r_state     <= S_IDLE;
        r_tens      <= 4'd0;
        r_ones      <= 4'd0;
        r_lim_t     <= w_sw_t;
        r_lim_o     <= w_sw_o;
        r_running   <= 1'b0;
        r_limit_hit <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start && w_lim_zero) begin
              r_state     <= S_DONE;
              r_limit_hit <= 1'b1;
              r_hit_pulse <= 1'b1;
            end else if (bus.start) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            if (bus.pause && !bus.start) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (bus.one_sec) begin
              r_tens <= w_nxt_t;
              r_ones <= w_nxt_o;
              if (w_nxt_hit) begin
                r_hit_pulse <= 1'b1;
                if (!WRAP) begin
                  r_state     <= S_DONE;
                  r_running   <= 1'b0;
                  r_limit_hit <= 1'b1;
                end
              end
            end
          end
          S_PAUSE: begin
            if (bus.start) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state     <= S_IDLE;
            r_running   <= 1'b0;
            r_limit_hit <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.num_out_1st = r_tens;
  assign bus.num_out_2nd = r_ones;
  assign bus.running     = r_running;
  assign bus.limit_hit   = r_limit_hit;
  assign bus.hit_pulse   = r_hit_pulse;

endmodule

// File: tb/tb_count_up_timer.sv
// Bench for count_up_timer: a stop-at-limit and a wrapping instance
// driven in lockstep and compared against an integer-seconds model.
module tb_count_up_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk;
  logic rst;

  count_up_timer_if bus0 ();
  count_up_timer_if bus1 ();

  count_up_timer #(
    .WRAP(1'b0), .DEF_TENS(4'd9), .DEF_ONES(4'd9)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  count_up_timer #(
    .WRAP(1'b1), .DEF_TENS(4'd9), .DEF_ONES(4'd9)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass;
  int ntot;

  int m_cnt [2];
  int m_lim [2];
  int m_st  [2];
  bit m_hit [2];

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("w0_tens", {4'd0, bus0.num_out_1st}, 8'(m_cnt[0] / 10));
    check("w0_ones", {4'd0, bus0.num_out_2nd}, 8'(m_cnt[0] % 10));
    check("w0_run",  {7'd0, bus0.running},  8'(m_st[0] == M_RUN));
    check("w0_lhit", {7'd0, bus0.limit_hit}, 8'(m_st[0] == M_DONE));
    check("w0_hitp", {7'd0, bus0.hit_pulse}, 8'(m_hit[0]));
    check("w1_tens", {4'd0, bus1.num_out_1st}, 8'(m_cnt[1] / 10));
    check("w1_ones", {4'd0, bus1.num_out_2nd}, 8'(m_cnt[1] % 10));
    check("w1_run",  {7'd0, bus1.running},  8'(m_st[1] == M_RUN));
    check("w1_lhit", {7'd0, bus1.limit_hit}, 8'(m_st[1] == M_DONE));
    check("w1_hitp", {7'd0, bus1.hit_pulse}, 8'(m_hit[1]));
  endtask

  function automatic void model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0;
      m_lim[w] = 99;
      m_st[w]  = M_IDLE;
      m_hit[w] = 1'b0;
    end
  endfunction

  // Count is plain seconds 0..99; the digits are derived as /10 and %10.
  function automatic void model_edge(input bit os, input bit st,
                                     input bit pa, input bit cl,
                                     input bit rc,
                                     input int s3, input int s4);
    for (int w = 0; w < 2; w++) begin
      m_hit[w] = 1'b0;
      if (cl) begin
        m_cnt[w] = 0;
        m_st[w]  = M_IDLE;
      end else if (rc) begin
        m_lim[w] = (s3 > 9 ? 9 : s3) * 10 + (s4 > 9 ? 9 : s4);
        m_cnt[w] = 0;
        m_st[w]  = M_IDLE;
      end else if (m_st[w] == M_IDLE) begin
        if (st && m_lim[w] == 0) begin
          m_st[w]  = M_DONE;
          m_hit[w] = 1'b1;
        end else if (st) begin
          m_st[w] = M_RUN;
        end
      end else if (m_st[w] == M_RUN) begin
        if (pa && !st) begin
          m_st[w] = M_PAUSE;
        end else if (os) begin
          if (w == 1 && m_cnt[w] == m_lim[w]) m_cnt[w] = 0;
          else m_cnt[w] = (m_cnt[w] + 1) % 100;
          if (m_cnt[w] == m_lim[w]) begin
            m_hit[w] = 1'b1;
            if (w == 0) m_st[w] = M_DONE;
          end
        end
      end else if (m_st[w] == M_PAUSE) begin
        if (st) m_st[w] = M_RUN;
      end
    end
  endfunction

  task automatic step(input bit os, input bit st, input bit pa,
                      input bit cl, input bit rc,
                      input logic [3:0] s3, input logic [3:0] s4);
    bus0.one_sec = os;     bus1.one_sec = os;
    bus0.start = st;       bus1.start = st;
    bus0.pause = pa;       bus1.pause = pa;
    bus0.clear_digit = cl; bus1.clear_digit = cl;
    bus0.reconfig = rc;    bus1.reconfig = rc;
    bus0.switch_num3 = s3; bus1.switch_num3 = s3;
    bus0.switch_num4 = s4; bus1.switch_num4 = s4;
    @(posedge clk);
    model_edge(os, st, pa, cl, rc, int'(s3), int'(s4));
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 4'hA, 4'h3);
  endtask

  task automatic cfg(input logic [3:0] s3, input logic [3:0] s4);
    step(0, 0, 0, 0, 1, s3, s4);
  endtask

  task automatic go();
    step(0, 1, 0, 0, 0, 4'h0, 4'h0);
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    rst   = 1'b0;
    bus0.one_sec = 0; bus1.one_sec = 0;
    bus0.start = 0;   bus1.start = 0;
    bus0.pause = 0;   bus1.pause = 0;
    bus0.clear_digit = 0; bus1.clear_digit = 0;
    bus0.reconfig = 0;    bus1.reconfig = 0;
    bus0.switch_num3 = 0; bus1.switch_num3 = 0;
    bus0.switch_num4 = 0; bus1.switch_num4 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    @(negedge clk);

    // Default limit 99 after reset; a few seconds from power-up
    go();
    ticks(3);

    // Limit 05: stop at 05 (wrap instance reloads)
    cfg(4'd0, 4'd5);
    go();
    ticks(7);

    // Limit 12: carry at 10
    cfg(4'd1, 4'd2);
    go();
    ticks(13);

    // Pause/resume, pause beats a coincident tick, start beats pause
    cfg(4'd9, 4'd9);
    go();
    ticks(3);
    step(0, 0, 1, 0, 0, 4'd0, 4'd0);
    ticks(4);
    go();
    ticks(1);
    step(1, 0, 1, 0, 0, 4'd0, 4'd0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0);
    step(1, 1, 1, 0, 0, 4'd0, 4'd0);

    // Limit 03: wrap sequence 01 02 03 00 01 02 03
    cfg(4'd0, 4'd3);
    go();
    ticks(7);

    // Clamp F/C to 99; reconfig beats start; clear mid-run
    cfg(4'hF, 4'hC);
    step(0, 1, 0, 0, 1, 4'hF, 4'hC);
    go();
    ticks(3);
    step(1, 1, 0, 1, 1, 4'd0, 4'd1);
    ticks(2);

    // Limit 00: immediate DONE with single pulse
    cfg(4'd0, 4'd0);
    go();
    ticks(2);
    go();

    // Asynchronous reset mid-run
    cfg(4'd0, 4'd5);
    go();
    ticks(2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Random traffic, limits biased low so completions occur
    for (int i = 0; i < 600; i++) begin
      logic [3:0] s3;
      logic [3:0] s4;
      bit os, st, pa, cl, rc;
      s3 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 1));
      s4 = 4'($urandom_range(0, 15));
      os = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 9) == 0);
      pa = ($urandom_range(0, 11) == 0);
      cl = ($urandom_range(0, 59) == 0);
      rc = ($urandom_range(0, 29) == 0);
      step(os, st, pa, cl, rc, s3, s4);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
